pid_multi: RTL and testbench

- Time-multiplexed, parametrised incremental PID for NCH motor channels, sharing one multiply/accumulate pipeline.
- Computes u[n] = u[n-1] + ((k1*e[n] - k2*e[n-1] + k3*e[n-2]) >>> SHIFT) per channel.
- Adds over the single-channel form: output saturation with clamped-state anti-windup, per-channel enable, sample handshake and overrun flag.
- Sits between the per-channel error subtractors and the PWM generators.

---
 rtl/pid_multi_if.sv | 33 +++
 rtl/pid_multi.sv | 207 ++++++++++++++++++++
 tb/tb_pid_multi.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_multi_if.sv
// Sample/result bus of the multiplexed PID: sample strobe, errors, gains and enables in,
// saturated outputs and sequence status out.
interface pid_multi_if #(
    parameter int NCH = 4,
    parameter int EW  = 32,
    parameter int KW  = 8,
    parameter int UW  = 32
);
    // Handshake: sample_valid is a one-cycle strobe taken only while busy is low; a strobe
    // seen while busy is dropped and answered with a one-cycle overrun pulse. u_valid pulses
    // once per accepted sample, on the edge the last channel is written back.
    logic                  sample_valid;
    logic [NCH*EW-1:0]     e_in;
    logic [NCH*KW-1:0]     k1;
    logic [NCH*KW-1:0]     k2;
    logic [NCH*KW-1:0]     k3;
    logic [NCH-1:0]        ch_en;
    logic [NCH*UW-1:0]     u_out;
    logic                  u_valid;
    logic                  busy;
    logic                  overrun;
    logic [NCH-1:0]        sat;

    modport master (
        output sample_valid, e_in, k1, k2, k3, ch_en,
        input  u_out, u_valid, busy, overrun, sat
    );

    modport slave (
        input  sample_valid, e_in, k1, k2, k3, ch_en,
        output u_out, u_valid, busy, overrun, sat
    );
endinterface

// File: rtl/pid_multi.sv
// Time-multiplexed incremental PID for NCH channels sharing one two-stage MAC pipeline,
// with output clamping, clamped-state anti-windup, per-channel enable and overrun detection.
module pid_multi #(
    parameter int NCH   = 4,
    parameter int EW    = 32,
    parameter int KW    = 8,
    parameter int UW    = 32,
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    pid_multi_if.slave  bus,
    output logic [1:0]  state_dbg
);
    localparam int PW = EW + KW + 1;
    localparam int AW = ((UW > PW) ? UW : PW) + 3;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);
    localparam logic signed [AW-1:0] U_MAX = {{(AW-UW+1){1'b0}}, {(UW-1){1'b1}}};
    localparam logic signed [AW-1:0] U_MIN = {{(AW-UW+1){1'b1}}, {(UW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ch_idx_q, ch_idx_d;
    logic signed [EW-1:0]   ebuf_q [NCH];
    logic signed [EW-1:0]   ebuf_d [NCH];
    logic signed [EW-1:0]   e1_q   [NCH];
    logic signed [EW-1:0]   e1_d   [NCH];
    logic signed [EW-1:0]   e2_q   [NCH];
    logic signed [EW-1:0]   e2_d   [NCH];
    logic signed [UW-1:0]   u_q    [NCH];
    logic signed [UW-1:0]   u_d    [NCH];
    logic [NCH-1:0]         sat_q, sat_d;
    logic signed [PW-1:0]   p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic                   s1_vld_q, s1_vld_d;
    logic [IW-1:0]          s1_idx_q, s1_idx_d;
    logic                   u_valid_q, u_valid_d;
    logic                   overrun_q, overrun_d;

    logic                   capture, issue;
    logic [KW-1:0]          g1, g2, g3;
    logic signed [EW-1:0]   e_cur, e_h1, e_h2;
    logic signed [AW-1:0]   sum, inc, acc, clamped;
    logic                   sat_hi, sat_lo;
    logic signed [UW-1:0]   u_res;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.sample_valid) state_d = S_RUN;
                S_RUN:   if (ch_idx_q == LAST) state_d = S_FLUSH;
                S_FLUSH: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        capture   = 1'b0;
        issue     = 1'b0;
        u_valid_d = 1'b0;
        overrun_d = 1'b0;
        if (!clear) begin
            case (state_q)
                S_IDLE:  capture = bus.sample_valid;
                S_RUN: begin
                    issue     = 1'b1;
                    overrun_d = bus.sample_valid;
                end
                S_FLUSH: begin
                    u_valid_d = 1'b1;
                    overrun_d = bus.sample_valid;
                end
                default: ;
            endcase
        end
    end

    // Stage 1: products for the channel being issued; gains are taken live here.
    always_comb begin
        g1    = bus.k1[int'(ch_idx_q)*KW +: KW];
        g2    = bus.k2[int'(ch_idx_q)*KW +: KW];
        g3    = bus.k3[int'(ch_idx_q)*KW +: KW];
        e_cur = ebuf_q[ch_idx_q];
        e_h1  = e1_q[ch_idx_q];
        e_h2  = e2_q[ch_idx_q];
        p1_d  = p1_q;
        p2_d  = p2_q;
        p3_d  = p3_q;
        if (issue) begin
            p1_d = PW'(e_cur) * PW'($signed({1'b0, g1}));
            p2_d = PW'(e_h1)  * PW'($signed({1'b0, g2}));
            p3_d = PW'(e_h2)  * PW'($signed({1'b0, g3}));
        end
        s1_vld_d = issue && !clear;
        s1_idx_d = issue ? ch_idx_q : s1_idx_q;
        ch_idx_d = ch_idx_q;
        if (clear || capture) ch_idx_d = '0;
        else if (issue)       ch_idx_d = ch_idx_q + IW'(1);
    end

    // Stage 2: increment, saturate; the clamped value becomes the new state.
    always_comb begin
        sum     = AW'(p1_q) - AW'(p2_q) + AW'(p3_q);
        inc     = sum >>> SHIFT;
        acc     = AW'(u_q[s1_idx_q]) + inc;
        sat_hi  = acc > U_MAX;
        sat_lo  = acc < U_MIN;
        clamped = sat_hi ? U_MAX : (sat_lo ? U_MIN : acc);
        u_res   = UW'(clamped);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ebuf_d[i] = ebuf_q[i];
            e1_d[i]   = e1_q[i];
            e2_d[i]   = e2_q[i];
            u_d[i]    = u_q[i];
        end
        sat_d = sat_q;
        if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                ebuf_d[i] = '0;
                e1_d[i]   = '0;
                e2_d[i]   = '0;
                u_d[i]    = '0;
            end
            sat_d = '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NCH; i++) ebuf_d[i] = bus.e_in[i*EW +: EW];
            end
            if (s1_vld_q) begin
                if (bus.ch_en[s1_idx_q]) begin
                    u_d[s1_idx_q]   = u_res;
                    sat_d[s1_idx_q] = sat_hi | sat_lo;
                    e2_d[s1_idx_q]  = e1_q[s1_idx_q];
                    e1_d[s1_idx_q]  = ebuf_q[s1_idx_q];
                end else begin
                    u_d[s1_idx_q]   = '0;
                    sat_d[s1_idx_q] = 1'b0;
                    e2_d[s1_idx_q]  = '0;
                    e1_d[s1_idx_q]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                ebuf_q[i] <= '0;
                e1_q[i]   <= '0;
                e2_q[i]   <= '0;
                u_q[i]    <= '0;
            end
            sat_q     <= '0;
            ch_idx_q  <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            u_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ebuf_q[i] <= ebuf_d[i];
                e1_q[i]   <= e1_d[i];
                e2_q[i]   <= e2_d[i];
                u_q[i]    <= u_d[i];
            end
            sat_q     <= sat_d;
            ch_idx_q  <= ch_idx_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            p3_q      <= p3_d;
            s1_vld_q  <= s1_vld_d;
            s1_idx_q  <= s1_idx_d;
            u_valid_q <= u_valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) bus.u_out[i*UW +: UW] = u_q[i];
    end

    assign bus.u_valid = u_valid_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.overrun = overrun_q;
    assign bus.sat     = sat_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_pid_multi.sv
// Directed and randomized bench for pid_multi against an arithmetic reference model
// that tracks each channel's output and error history per accepted sample.
module tb_pid_multi;
    localparam int NCH = 4, EW = 16, KW = 8, UW = 16, SHIFT = 0;
    localparam longint U_MAX = (longint'(1) << (UW - 1)) - 1;
    localparam longint U_MIN = -(longint'(1) << (UW - 1));

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] state_dbg;

    pid_multi_if #(.NCH(NCH), .EW(EW), .KW(KW), .UW(UW)) bus ();

    pid_multi #(.NCH(NCH), .EW(EW), .KW(KW), .UW(UW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int             e_val [NCH];
    int             k1_val[NCH], k2_val[NCH], k3_val[NCH];
    logic [NCH-1:0] en_val;

    longint m_u [NCH];
    longint m_e1[NCH];
    longint m_e2[NCH];
    logic   m_sat[NCH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NCH; i++) begin
            bus.e_in[i*EW +: EW] = EW'(e_val[i]);
            bus.k1[i*KW +: KW]   = KW'(k1_val[i]);
            bus.k2[i*KW +: KW]   = KW'(k2_val[i]);
            bus.k3[i*KW +: KW]   = KW'(k3_val[i]);
        end
        bus.ch_en = en_val;
    endtask

    task automatic set_all(input int e, input int a, input int b, input int c,
                           input logic [NCH-1:0] en);
        for (int i = 0; i < NCH; i++) begin
            e_val[i]  = e;
            k1_val[i] = a;
            k2_val[i] = b;
            k3_val[i] = c;
        end
        en_val = en;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_u[i]   = 0;
            m_e1[i]  = 0;
            m_e2[i]  = 0;
            m_sat[i] = 1'b0;
        end
    endtask

    // u[n] = clamp(u[n-1] + ((k1*e[n] - k2*e[n-1] + k3*e[n-2]) >>> SHIFT))
    task automatic model_sample();
        longint inc, acc;
        for (int i = 0; i < NCH; i++) begin
            if (!en_val[i]) begin
                m_u[i]   = 0;
                m_e1[i]  = 0;
                m_e2[i]  = 0;
                m_sat[i] = 1'b0;
            end else begin
                inc = (longint'(k1_val[i]) * e_val[i] - longint'(k2_val[i]) * m_e1[i]
                       + longint'(k3_val[i]) * m_e2[i]) >>> SHIFT;
                acc = m_u[i] + inc;
                m_sat[i] = (acc > U_MAX) || (acc < U_MIN);
                m_u[i]   = (acc > U_MAX) ? U_MAX : ((acc < U_MIN) ? U_MIN : acc);
                m_e2[i]  = m_e1[i];
                m_e1[i]  = e_val[i];
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("%s_u%0d", tag, i), $signed(bus.u_out[i*UW +: UW]), m_u[i]);
            check($sformatf("%s_sat%0d", tag, i), bus.sat[i], m_sat[i]);
        end
    endtask

    // Strobe one sample, wait for its u_valid and compare against the model.
    // Returns right after the u_valid edge so a following call is back-to-back.
    task automatic run_sample(input string tag);
        int n;
        apply_inputs();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        model_sample();
        check({tag, "_busy_start"}, bus.busy, 1);
        check({tag, "_uvalid_low"}, bus.u_valid, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.u_valid !== 1'b1 && n < NCH + 8);
        check({tag, "_latency"}, n, NCH + 1);
        check({tag, "_busy_end"}, bus.busy, 0);
        check_outputs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sample_valid = 1'b0;
        set_all(0, 0, 0, 0, '1);
        apply_inputs();
        model_reset();

        // reset state
        repeat (2) tick();
        check_outputs("rst");
        check("rst_uvalid", bus.u_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        reset_n = 1'b1;
        tick();

        // single step: ch0 error 10, gains (107,104,2)
        set_all(0, 107, 104, 2, '1);
        e_val[0] = 10;
        run_sample("step1");
        check("step1_u0_const", $signed(bus.u_out[UW-1:0]), 1070);
        run_sample("step2");
        check("step2_u0_const", $signed(bus.u_out[UW-1:0]), 1100);
        run_sample("step3");
        check("step3_u0_const", $signed(bus.u_out[UW-1:0]), 1150);

        // saturation and anti-windup
        set_all(1000, 255, 0, 0, '1);
        run_sample("sat1");
        check("sat1_u0_const", $signed(bus.u_out[UW-1:0]), 32767);
        check("sat1_flag_const", bus.sat[0], 1);
        set_all(-1, 1, 0, 0, '1);
        run_sample("sat2");
        check("sat2_u0_const", $signed(bus.u_out[UW-1:0]), 32766);
        check("sat2_flag_const", bus.sat[0], 0);

        // overrun: second strobe two edges after the first is dropped
        set_all(0, 2, 1, 0, '1);
        e_val[0] = 3; e_val[1] = -4; e_val[2] = 7; e_val[3] = 100;
        apply_inputs();
        bus.sample_valid = 1'b1;
        tick();
        model_sample();
        for (int c = 1; c <= NCH + 1; c++) begin
            if (c == 2) begin
                bus.e_in = {NCH{EW'(999)}};
                bus.sample_valid = 1'b1;
            end else begin
                bus.sample_valid = 1'b0;
            end
            tick();
            check($sformatf("ovr_flag_c%0d", c), bus.overrun, (c == 2));
            check($sformatf("ovr_uvalid_c%0d", c), bus.u_valid, (c == NCH + 1));
        end
        check_outputs("ovr");
        e_val[0] = 1; e_val[1] = 2; e_val[2] = 3; e_val[3] = 4;
        run_sample("b2b");

        // clear mid-RUN
        set_all(10, 107, 104, 2, '1);
        apply_inputs();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
        check("clr_busy", bus.busy, 0);
        check_outputs("clr");
        for (int c = 0; c < NCH + 2; c++) begin
            tick();
            check($sformatf("clr_no_uvalid_%0d", c), bus.u_valid, 0);
        end
        run_sample("clr_hist");
        check("clr_hist_u0_const", $signed(bus.u_out[UW-1:0]), 1070);

        // asynchronous reset mid-sequence
        apply_inputs();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        check("arst_uvalid", bus.u_valid, 0);
        check("arst_busy", bus.busy, 0);
        #2 reset_n = 1'b1;
        tick();
        check("arst_no_uvalid", bus.u_valid, 0);

        // per-channel enable
        set_all(5, 1, 0, 0, 4'b1011);
        run_sample("en1");
        check("en1_u2_const", $signed(bus.u_out[2*UW +: UW]), 0);
        check("en1_u3_const", $signed(bus.u_out[3*UW +: UW]), 5);
        run_sample("en2");
        check("en2_u2_const", $signed(bus.u_out[2*UW +: UW]), 0);
        check("en2_u0_const", $signed(bus.u_out[UW-1:0]), 10);

        // randomized samples, gains and enables
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NCH; i++) begin
                if (r % 3 == 0) e_val[i] = int'($urandom_range(0, 65535)) - 32768;
                else            e_val[i] = int'($urandom_range(0, 200)) - 100;
                k1_val[i] = int'($urandom_range(0, 255));
                k2_val[i] = int'($urandom_range(0, 255));
                k3_val[i] = int'($urandom_range(0, 255));
            end
            en_val = NCH'($urandom_range(0, 15)) | NCH'($urandom_range(0, 15));
            run_sample($sformatf("rnd%0d", r));
        end

        tick();
        check("final_uvalid_drop", bus.u_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
